// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch front end. Holds the program counter, issues sequential
//   word reads to instruction memory, buffers in-order responses together with
//   their PCs, and hands them to decode. A redirect flushes the buffer, marks
//   every in-flight fetch as stale and restarts fetch at the new PC.
//
// Ports
//   clk, rst_n                     clock (rising edge), async active-low reset
//   imem_req_valid/ready/addr      fetch request channel to instruction memory
//   imem_rsp_valid/data            in-order read responses, one per request
//   instr_valid/ready, instr,
//   instr_pc                       queue head presented to decode
//   redirect_valid, redirect_pc    flush and restart fetch at redirect_pc
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc;

  // instruction queue
  logic [31:0]   iq_data [DEPTH];
  logic [31:0]   iq_pc   [DEPTH];
  logic [AW-1:0] iq_head;
  logic [AW-1:0] iq_tail;
  logic [CW-1:0] count;

  // addresses of accepted but not yet answered requests
  logic [31:0]   aq      [DEPTH];
  logic [AW-1:0] aq_head;
  logic [AW-1:0] aq_tail;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] kill;

  logic [CW:0]   used;
  logic          credit_ok;
  logic          req_fire;
  logic          rsp_ok;
  logic          rsp_keep;
  logic          pop;

  // Killed requests still hold a credit until their response drains, which
  // keeps the queue from ever overflowing when they arrive.
  assign used      = {1'b0, count} + {1'b0, outstanding};
  assign credit_ok = used < (CW + 1)'(DEPTH);

  assign imem_req_valid = rst_n && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc;

  assign instr_valid = count != '0;
  assign instr       = iq_data[iq_head];
  assign instr_pc    = iq_pc[iq_head];

  assign req_fire = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_ok   = imem_rsp_valid && (outstanding != '0);
  assign rsp_keep = rsp_ok && (kill == '0);
  assign pop      = instr_valid && instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      iq_head     <= '0;
      iq_tail     <= '0;
      count       <= '0;
      aq_head     <= '0;
      aq_tail     <= '0;
      outstanding <= '0;
      kill        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        iq_data[i] <= '0;
        iq_pc[i]   <= '0;
        aq[i]      <= '0;
      end
    end else begin
      // The address queue drains with responses regardless of redirects, so
      // it stays aligned with the memory's in-order response stream.
      if (rsp_ok) begin
        aq_head <= aq_head + AW'(1);
      end

      if (redirect_valid) begin
        iq_head     <= '0;
        iq_tail     <= '0;
        count       <= '0;
        pc          <= redirect_pc & 32'hFFFF_FFFC;
        kill        <= outstanding - CW'(rsp_ok);
        outstanding <= outstanding - CW'(rsp_ok);
      end else begin
        if (req_fire) begin
          aq[aq_tail] <= pc;
          aq_tail     <= aq_tail + AW'(1);
          pc          <= pc + 32'd4;
        end

        if (rsp_keep) begin
          iq_data[iq_tail] <= imem_rsp_data;
          iq_pc[iq_tail]   <= aq[aq_head];
          iq_tail          <= iq_tail + AW'(1);
        end

        if (pop) begin
          iq_head <= iq_head + AW'(1);
        end

        if (rsp_ok && (kill != '0)) begin
          kill <= kill - CW'(1);
        end

        count       <= count + CW'(rsp_keep) - CW'(pop);
        outstanding <= outstanding + CW'(req_fire) - CW'(rsp_ok);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // In-flight fetch as seen by the memory model; a redirect marks it stale.
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] model_q[$];    // PCs the decode stage is owed, in order
  logic [31:0] model_pc;      // next address fetch must request
  logic [31:0] addr_log[$];
  logic [31:0] seen_pc[$];
  int          cyc;
  int          last_due;
  int          errors;
  int          checks;
  int          dut_acc;
  int          dut_pops;

  int          p_ready;
  int          p_mready;
  int          p_redir;
  int          lat_lo;
  int          lat_hi;
  bit          force_redir;
  logic [31:0] force_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    bit          rdy;
    bit          mrdy;
    bit          redir;
    bit          rsp;
    bit          exp_rv;
    bit          acc;
    logic [31:0] rpc;
    mreq_t       e;
    int          d;

    @(negedge clk);
    if (model_q.size() != 0) begin
      chk("instr_valid", instr_valid, 1);
      chk("instr_pc", instr_pc, model_q[0]);
      chk("instr", instr, mem_word(model_q[0]));
    end else begin
      chk("instr_valid_empty", instr_valid, 0);
    end

    rdy   = $urandom_range(99) < p_ready;
    mrdy  = $urandom_range(99) < p_mready;
    redir = force_redir || ($urandom_range(99) < p_redir);
    rpc   = force_redir ? force_pc : $urandom;
    force_redir = 1'b0;
    rsp   = (mem_q.size() != 0) && (mem_q[0].due <= cyc);

    instr_ready    = rdy;
    imem_req_ready = mrdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(mem_q[0].addr) : $urandom;
    #1;

    exp_rv = !redir && ((model_q.size() + mem_q.size()) < DEPTH);
    chk("req_valid", imem_req_valid, exp_rv);
    chk("req_addr", imem_req_addr, model_pc);

    if (imem_req_valid && mrdy) begin
      dut_acc++;
      addr_log.push_back(imem_req_addr);
    end
    if (instr_valid && rdy) begin
      dut_pops++;
      seen_pc.push_back(instr_pc);
    end

    acc = exp_rv && mrdy;
    if ((model_q.size() != 0) && rdy) void'(model_q.pop_front());
    if (rsp) begin
      e = mem_q.pop_front();
      if (!e.stale && !redir) model_q.push_back(e.addr);
    end
    if (redir) begin
      model_q.delete();
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      model_pc = rpc & 32'hFFFF_FFFC;
      seen_pc.delete();
    end else if (acc) begin
      d = cyc + $urandom_range(lat_hi, lat_lo);
      if (d <= last_due) d = last_due + 1;
      mem_q.push_back('{addr: model_pc, due: d, stale: 1'b0});
      last_due = d;
      model_pc = model_pc + 32'd4;
    end
    cyc++;
  endtask

  // Called right after step() returns, a little after the falling edge.
  task automatic pulse_reset();
    #2;
    rst_n          = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("rst_async_instr_valid", instr_valid, 0);
    chk("rst_async_req_valid", imem_req_valid, 0);
    chk("rst_async_req_addr", imem_req_addr, RESET_PC);
    model_q.delete();
    mem_q.delete();
    model_pc = RESET_PC;
    last_due = cyc;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    errors = 0; checks = 0; cyc = 0; last_due = 0;
    dut_acc = 0; dut_pops = 0;
    model_pc = RESET_PC;
    force_redir = 1'b0; force_pc = '0;
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    repeat (3) @(negedge clk);
    chk("reset_req_valid", imem_req_valid, 0);
    chk("reset_req_addr", imem_req_addr, RESET_PC);
    chk("reset_instr_valid", instr_valid, 0);
    chk("reset_instr", instr, 0);
    chk("reset_instr_pc", instr_pc, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // streaming with single-cycle memory
    p_ready = 100; p_mready = 100; p_redir = 0; lat_lo = 1; lat_hi = 1;
    dut_pops = 0;
    run(20);
    chk("throughput_pops", dut_pops, 18);

    // decode stalled from a fresh start: only DEPTH fetches may be issued
    pulse_reset();
    p_ready = 0; dut_acc = 0;
    run(10);
    chk("stall_accepts", dut_acc, DEPTH);
    chk("stall_req_valid", imem_req_valid, 0);
    p_ready = 100;
    run(15);

    // two fetches in flight with 3-cycle memory, then redirect
    pulse_reset();
    lat_lo = 3; lat_hi = 3;
    run(2);
    force_redir = 1'b1; force_pc = 32'h0000_0103;
    run(12);
    chk("redir_first_pc", (seen_pc.size() != 0) ? seen_pc[0] : 32'hDEAD_BEEF, 32'h0000_0100);

    // redirect coinciding with a response and a handshake, to the top of memory
    lat_lo = 1; lat_hi = 1;
    run(6);
    addr_log.delete();
    force_redir = 1'b1; force_pc = 32'hFFFF_FFF8;
    run(6);
    chk("wrap_addr0", (addr_log.size() > 0) ? addr_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
    chk("wrap_addr1", (addr_log.size() > 1) ? addr_log[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    chk("wrap_addr2", (addr_log.size() > 2) ? addr_log[2] : 32'hDEAD_BEEF, 32'h0000_0000);

    // reset mid-stream
    pulse_reset();
    run(8);

    // randomized traffic
    p_ready = 70; p_mready = 75; p_redir = 4; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(999) < 5) pulse_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch unit feeding the decode stage. It holds the program counter, issues sequential word reads to instruction memory over a valid/ready request channel, and buffers in-order responses in a DEPTH-entry queue. It presents each instruction with its PC to decode over a valid/ready handshake. A redirect (branch or jump target) flushes buffered and in-flight fetches and restarts fetch at the new PC.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- DEPTH, 4: instruction queue entries; power of two, ≥2. Also caps in-flight requests.
- clk  input  1  clock, rising-edge.
- rst_n  input  1  reset; asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_rsp_valid  input  1  read data valid; one response per accepted request, in order, ≥1 cycle after acceptance.
- imem_rsp_data  input  32  instruction word.
- instr_valid  output  1  queue head valid to decode.
- instr_ready  input  1  decode consumes head.
- instr  output  32  queue head instruction.
- instr_pc  output  32  PC of queue head.
- redirect_valid  input  1  flush and restart fetch.
- redirect_pc  input  32  new fetch PC; bits [1:0] ignored and forced to 0.

## Operation
- State: pc (32b), queue of DEPTH {instr, pc} entries with count, in-flight address queue (DEPTH entries), outstanding counter, kill counter.
- Issue: imem_req_valid = rst_n && !redirect_valid && (count + outstanding < DEPTH), from registered values with no same-cycle bypass. imem_req_addr = pc. Request and address may change while not accepted; memory samples only on valid&&ready.
- On acceptance: push pc into the address queue, outstanding+1, pc <= pc+4. Wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- Response with kill==0: pop the address queue and push {imem_rsp_data, addr} into the instruction queue; outstanding-1.
- Response with kill>0: data discarded; kill-1, outstanding-1, address queue popped.
- Response with outstanding==0 is a protocol violation: ignored, no state change.
- Decode: instr_valid = count!=0. instr/instr_pc show the head. On valid&&ready, pop the head.
- Redirect, highest priority:
  - Queue cleared.
  - pc <= {redirect_pc[31:2],2'b00}.
  - kill <= outstanding − (imem_rsp_valid ? 1 : 0).
  - No request issued that cycle.
  - An instr handshake in the redirect cycle counts as completed.
- Back-to-back redirects: the last one wins; kill is recomputed each time.
- Overflow is impossible: the credit rule guarantees push never hits a full queue. A push and a pop in the same cycle leave count unchanged.

## Timing
- Reset values: imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, count=0, outstanding=0, kill=0.
- First request is asserted in the first cycle after rst_n deasserts.
- Request accepted in cycle N, response in cycle N+k: instr_valid is high in cycle N+k+1.
- With DEPTH≥3, 1-cycle memory and instr_ready held high, throughput is sustained at one instruction per cycle.
- Redirect in cycle R: instr_valid=0 in R+1. First new request is in R+1, with address redirect_pc, provided the credit rule passes (killed in-flight requests still count).
- Reset mid-operation: asynchronous clear of all state. The memory is reset alongside, so no stale responses arrive.

## Test plan
- Reset release, 1-cycle memory, instr_ready=1 → instrs for PCs 0,4,8,… appear one per cycle from cycle 3; instr equals memory contents at instr_pc.
- instr_ready=0 for 10 cycles → exactly DEPTH=4 requests issued, then imem_req_valid=0; on release, PCs continue in order with none lost or duplicated.
- 3-cycle memory latency, two requests in flight, redirect_pc=32'h0000_0103 → both stale responses discarded; next instr_pc=32'h0000_0100; queue empty in the following cycle.
- Redirect in the same cycle as imem_rsp_valid and an instr handshake → the handshake completes, the response is dropped, kill=outstanding−1, and no stale instruction reaches decode.
- pc=32'hFFFF_FFF8 → fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst_n pulsed low mid-stream for one cycle → instr_valid=0 immediately (asynchronously); fetch restarts at RESET_PC.
